// File: rtl/cpu_mem_responder_if.sv
// ----------------------------------------------------------------------------
// cpu_mem_responder_if
// Bundles the CPU memory bus and the boot-loader stream that connect to the
// memory-side responder.
//
//   iMemAddr   [ADDR_W] CPU byte address
//   iMemData   [32]     CPU write data
//   oMemData   [32]     read data to CPU
//   iMemRead            CPU read strobe
//   iMemWrite           CPU write strobe
//   iLdValid            loader word valid
//   iLdData    [32]     loader word
//   iLdLast             final loader word, qualified by iLdValid
//   oLdReady            responder accepts a loader word
//   oCpuRstN            active-low reset to the CPU
//   oFault              sticky illegal-access flag
//   oFaultAddr [ADDR_W] address of the first illegal access
//
// slave  : the responder side
// master : the CPU/loader side
// ----------------------------------------------------------------------------
interface cpu_mem_responder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] iMemAddr;
    logic [31:0]       iMemData;
    logic [31:0]       oMemData;
    logic              iMemRead;
    logic              iMemWrite;
    logic              iLdValid;
    logic [31:0]       iLdData;
    logic              iLdLast;
    logic              oLdReady;
    logic              oCpuRstN;
    logic              oFault;
    logic [ADDR_W-1:0] oFaultAddr;

    modport slave (
        input  iMemAddr, iMemData, iMemRead, iMemWrite,
        input  iLdValid, iLdData, iLdLast,
        output oMemData, oLdReady, oCpuRstN, oFault, oFaultAddr
    );

    modport master (
        output iMemAddr, iMemData, iMemRead, iMemWrite,
        output iLdValid, iLdData, iLdLast,
        input  oMemData, oLdReady, oCpuRstN, oFault, oFaultAddr
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// ----------------------------------------------------------------------------
// cpu_mem_responder
// Word-addressed RAM behind the CPU memory bus. After reset it boot-loads a
// program image from the loader stream into RAM starting at word 0 while the
// CPU is held in reset, then releases the CPU and serves single-cycle reads
// and writes, flagging misaligned or out-of-range accesses.
//
// Ports:
//   iClk  system clock, rising edge
//   nRst  synchronous active-low reset
//   bus   cpu_mem_responder_if.slave (CPU bus + loader stream + status)
// ----------------------------------------------------------------------------
module cpu_mem_responder #(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned ADDR_W       = 32,
    parameter logic [31:0] DEFAULT_DATA = 32'h0000_0000
) (
    input logic                iClk,
    input logic                nRst,
    cpu_mem_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    // One extra bit so 4*DEPTH is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * DEPTH);
    localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        StLoad,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              ld_ready_q, ld_ready_d;

    logic [31:0]       mem_q [DEPTH];

    logic              addr_legal;
    logic [IDX_W-1:0]  addr_idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [31:0]       mem_wdata;

    assign addr_idx   = bus.iMemAddr[IDX_W+1:2];
    assign addr_legal = (bus.iMemAddr[1:0] == 2'b00) && ({1'b0, bus.iMemAddr} < ADDR_LIMIT);

    // Next-state and RAM write-port selection.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        cpu_rst_n_d  = cpu_rst_n_q;
        ld_ready_d   = ld_ready_q;
        mem_we       = 1'b0;
        mem_waddr    = ptr_q;
        mem_wdata    = bus.iLdData;

        unique case (state_q)
            StLoad: begin
                if (bus.iLdValid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = bus.iLdData;
                    ptr_d     = ptr_q + 1'b1;
                    // The full-pointer guard stops a loader without last from wrapping.
                    if (bus.iLdLast || (ptr_q == PTR_LAST)) begin
                        state_d     = StRun;
                        cpu_rst_n_d = 1'b1;
                        ld_ready_d  = 1'b0;
                    end
                end
            end
            StRun: begin
                if (bus.iMemWrite && addr_legal) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_idx;
                    mem_wdata = bus.iMemData;
                end
                if ((bus.iMemRead || bus.iMemWrite) && !addr_legal) begin
                    fault_d = 1'b1;
                    if (!fault_q) begin
                        fault_addr_d = bus.iMemAddr;
                    end
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!nRst) begin
            state_q      <= StLoad;
            ptr_q        <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            cpu_rst_n_q  <= 1'b0;
            ld_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            ld_ready_q   <= ld_ready_d;
        end
    end

    // RAM contents survive reset; the write port is only blocked while in reset.
    always_ff @(posedge iClk) begin
        if (nRst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Zero-latency read; the strobe does not gate data because fetches run strobe-low.
    always_comb begin
        bus.oMemData = DEFAULT_DATA;
        if ((state_q == StRun) && addr_legal) begin
            bus.oMemData = mem_q[addr_idx];
        end
    end

    assign bus.oLdReady   = ld_ready_q;
    assign bus.oCpuRstN   = cpu_rst_n_q;
    assign bus.oFault     = fault_q;
    assign bus.oFaultAddr = fault_addr_q;

endmodule
